// File: rtl/my_node_info.sv
// rtl/my_node_info.sv - per-node state register for EER-RL clustering
//
// Decodes the filtered packet type on each en_MNI pulse and updates this
// node's hop distance to the sink, initial Q-value, cluster-head role and
// low-energy flag.
//
// Ports:
//   clk            system clock, rising-edge state updates
//   nrst           asynchronous active-low reset
//   en_MNI         sample packet fields on this edge
//   fPktType       3-bit packet type (HB/CHE/INV/rsvd/CHT/DATA/invalid)
//   energy         residual energy, unsigned 2.14
//   destinationID  destination node ID in the packet
//   hops           hop count in the packet
//   timeslot       TDMA slot from CHT (not stored)
//   e_threshold    low-energy threshold, unsigned 2.14
//   myNodeID       constant NODE_ID
//   hopsFromSink   registered hop distance to the sink
//   myQValue       registered initial Q-value (energy / hops)
//   role           1 = cluster head for the current round
//   low_E          1 = residual energy below threshold

module my_node_info #(
    parameter logic [15:0] NODE_ID = 16'h000C
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en_MNI,
    input  logic [2:0]  fPktType,
    input  logic [15:0] energy,
    input  logic [15:0] destinationID,
    input  logic [15:0] hops,
    input  logic [15:0] timeslot,
    input  logic [15:0] e_threshold,
    output logic [15:0] myNodeID,
    output logic [15:0] hopsFromSink,
    output logic [15:0] myQValue,
    output logic        role,
    output logic        low_E
);

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_CHT  = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;

    // Set by an accepted heartbeat, cleared by DATA or a CHT for this node,
    // so only the first heartbeat of a round is taken.
    logic        hb_lock;

    logic        for_me;
    logic [15:0] quotient;
    logic [15:0] q_value_next;
    logic        low_e_next;

    // The slot number only matters to the TDMA scheduler downstream.
    logic        unused_timeslot;
    assign unused_timeslot = ^timeslot;

    assign myNodeID = NODE_ID;
    assign for_me   = (destinationID == NODE_ID);

    // Single-cycle restoring divider: energy / hops, truncated.
    // With hops == 0 the quotient is all ones, but that result is never
    // used because a zero-hop heartbeat stores the raw energy instead.
    always_comb begin
        logic [16:0] rem;
        rem      = '0;
        quotient = '0;
        for (int i = 15; i >= 0; i--) begin
            rem = {rem[15:0], energy[i]};
            if (rem >= {1'b0, hops}) begin
                rem         = rem - {1'b0, hops};
                quotient[i] = 1'b1;
            end
        end
    end

    assign q_value_next = (hops == 16'd0) ? energy : quotient;
    assign low_e_next   = (energy < e_threshold);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hopsFromSink <= '0;
            myQValue     <= '0;
            role         <= 1'b0;
            low_E        <= 1'b0;
            hb_lock      <= 1'b0;
        end else if (en_MNI) begin
            case (fPktType)
                PKT_HB: begin
                    if (!hb_lock) begin
                        hopsFromSink <= hops;
                        myQValue     <= q_value_next;
                        low_E        <= low_e_next;
                        role         <= 1'b0;   // new round starts as member
                        hb_lock      <= 1'b1;
                    end
                end
                PKT_CHE: begin
                    if (for_me) begin
                        role <= 1'b1;
                    end
                end
                PKT_CHT: begin
                    if (for_me) begin
                        hb_lock <= 1'b0;
                    end
                end
                PKT_DATA: begin
                    hb_lock <= 1'b0;
                end
                default: begin
                    // INV, reserved and invalid types leave state alone
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_node_info.sv
// tb/tb_my_node_info.sv - self-checking bench for my_node_info

module tb_my_node_info;

    localparam logic [15:0] NODE_ID = 16'h000C;

    logic        clk;
    logic        nrst;
    logic        en_MNI;
    logic [2:0]  fPktType;
    logic [15:0] energy;
    logic [15:0] destinationID;
    logic [15:0] hops;
    logic [15:0] timeslot;
    logic [15:0] e_threshold;
    logic [15:0] myNodeID;
    logic [15:0] hopsFromSink;
    logic [15:0] myQValue;
    logic        role;
    logic        low_E;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 0;

    my_node_info #(.NODE_ID(NODE_ID)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en_MNI       (en_MNI),
        .fPktType     (fPktType),
        .energy       (energy),
        .destinationID(destinationID),
        .hops         (hops),
        .timeslot     (timeslot),
        .e_threshold  (e_threshold),
        .myNodeID     (myNodeID),
        .hopsFromSink (hopsFromSink),
        .myQValue     (myQValue),
        .role         (role),
        .low_E        (low_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: node state after each sampled packet.
    logic [15:0] m_hops = '0;
    logic [15:0] m_q    = '0;
    logic        m_role = 1'b0;
    logic        m_lowe = 1'b0;
    bit          m_lock = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_hops = '0; m_q = '0; m_role = 1'b0; m_lowe = 1'b0; m_lock = 1'b0;
        end else if (en_MNI) begin
            if (fPktType == 3'd0 && !m_lock) begin
                m_hops = hops;
                if (hops == 16'd0) m_q = energy;
                else               m_q = 16'(int'(energy) / int'(hops));
                m_lowe = int'(energy) < int'(e_threshold);
                m_role = 1'b0;
                m_lock = 1'b1;
            end
            if (fPktType == 3'd1 && destinationID == NODE_ID) m_role = 1'b1;
            if (fPktType == 3'd4 && destinationID == NODE_ID) m_lock = 1'b0;
            if (fPktType == 3'd5) m_lock = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmp_node_id", myNodeID, NODE_ID);
            chk("cmp_hops", hopsFromSink, m_hops);
            chk("cmp_qvalue", myQValue, m_q);
            chk("cmp_role", {15'd0, role}, {15'd0, m_role});
            chk("cmp_low_e", {15'd0, low_E}, {15'd0, m_lowe});
        end
    end

    task automatic expect_outs(input string name, input logic [15:0] h, input logic [15:0] q,
                               input logic r, input logic le);
        chk({name, "_hops"}, hopsFromSink, h);
        chk({name, "_q"}, myQValue, q);
        chk({name, "_role"}, {15'd0, role}, {15'd0, r});
        chk({name, "_lowe"}, {15'd0, low_E}, {15'd0, le});
        chk({name, "_id"}, myNodeID, NODE_ID);
    endtask

    // One-cycle enable pulse; returns on the falling edge after the sample edge.
    task automatic send(input logic [2:0] t, input logic [15:0] e, input logic [15:0] dst,
                        input logic [15:0] h, input logic [15:0] ts, input logic [15:0] th);
        @(negedge clk);
        fPktType = t; energy = e; destinationID = dst; hops = h;
        timeslot = ts; e_threshold = th; en_MNI = 1'b1;
        @(negedge clk);
        en_MNI = 1'b0;
        #1;
    endtask

    initial begin
        nrst = 1'b0; en_MNI = 1'b0; fPktType = 3'd0; energy = '0;
        destinationID = '0; hops = '0; timeslot = '0; e_threshold = '0;
        repeat (2) @(negedge clk);
        expect_outs("reset", 16'd0, 16'd0, 1'b0, 1'b0);
        nrst = 1'b1;
        cmp_on = 1'b1;

        // Directed sequence with hand-computed expectations
        send(3'd0, 16'h8000, 16'd0, 16'd1, 16'd0, 16'h3333);
        expect_outs("hb1", 16'd1, 16'h8000, 1'b0, 1'b0);
        send(3'd0, 16'h7FC0, 16'd0, 16'd2, 16'd0, 16'h3333);
        expect_outs("hb_dropped", 16'd1, 16'h8000, 1'b0, 1'b0);
        send(3'd1, 16'h7FC0, 16'd32, 16'd2, 16'd0, 16'h3333);
        expect_outs("che_other", 16'd1, 16'h8000, 1'b0, 1'b0);
        send(3'd2, 16'h7FC0, 16'd32, 16'd2, 16'd0, 16'h3333);
        expect_outs("inv", 16'd1, 16'h8000, 1'b0, 1'b0);
        send(3'd1, 16'h7FC0, NODE_ID, 16'd2, 16'd0, 16'h3333);
        expect_outs("che_me", 16'd1, 16'h8000, 1'b1, 1'b0);
        send(3'd4, 16'h7FC0, 16'd21, 16'd2, 16'd4, 16'h3333);
        expect_outs("cht_other", 16'd1, 16'h8000, 1'b1, 1'b0);
        send(3'd5, 16'h7FC0, 16'd14, 16'd2, 16'd0, 16'h3333);
        expect_outs("data", 16'd1, 16'h8000, 1'b1, 1'b0);
        send(3'd0, 16'h6000, 16'd0, 16'd1, 16'd0, 16'h3333);
        expect_outs("hb2", 16'd1, 16'h6000, 1'b0, 1'b0);
        send(3'd4, 16'h6000, NODE_ID, 16'd1, 16'd5, 16'h3333);
        send(3'd0, 16'h2000, 16'd0, 16'd4, 16'd0, 16'h3333);
        expect_outs("hb_div4", 16'd4, 16'h0800, 1'b0, 1'b1);
        send(3'd5, 16'h2000, 16'd0, 16'd4, 16'd0, 16'h3333);
        send(3'd0, 16'h1234, 16'd0, 16'd0, 16'd0, 16'h3333);
        expect_outs("hb_hops0", 16'd0, 16'h1234, 1'b0, 1'b1);
        send(3'd5, 16'h1234, 16'd0, 16'd0, 16'd0, 16'h3333);
        send(3'd0, 16'hFFFF, 16'd0, 16'd7, 16'd0, 16'hFFFF);
        expect_outs("hb_div7", 16'd7, 16'h2492, 1'b0, 1'b0);
        send(3'd7, 16'h0001, NODE_ID, 16'd3, 16'd0, 16'h3333);
        expect_outs("type7", 16'd7, 16'h2492, 1'b0, 1'b0);
        send(3'd1, 16'h0001, NODE_ID, 16'd3, 16'd0, 16'h3333);

        // Asynchronous reset between clock edges, with an enable pending
        @(posedge clk);
        en_MNI = 1'b1; fPktType = 3'd5;
        #2 nrst = 1'b0;
        #1 expect_outs("async_rst", 16'd0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        en_MNI = 1'b0;
        nrst = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            en_MNI = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2: fPktType = 3'd0;
                3, 4:    fPktType = 3'd1;
                5:       fPktType = 3'd4;
                6:       fPktType = 3'd5;
                default: fPktType = 3'($urandom_range(0, 7));
            endcase
            destinationID = ($urandom_range(0, 1) == 0) ? NODE_ID : 16'($urandom);
            hops          = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
            energy        = 16'($urandom);
            e_threshold   = 16'($urandom);
            timeslot      = 16'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #3 nrst = 1'b0;
                @(negedge clk);
                nrst = 1'b1;
            end
        end

        @(negedge clk);
        en_MNI = 1'b0;
        @(negedge clk);
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
